// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  // Divider control states: waiting for operands, iterating, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Quotient reported for a zero divisor. The top slices it to its own width.
  localparam logic [63:0] DBZ_QUOTIENT = '1;

  // Step counter width. It can hold the value WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step. The partial remainder is shifted left and takes
// in the next dividend bit. The divisor is subtracted only if the result
// stays non-negative, and that decision becomes the next quotient bit.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   diff;

  // Trial subtraction. diff is only kept when it fits, so WIDTH+1 bits are enough.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    q_bit   = (shifted >= {2'b00, divisor});
    diff    = shifted[WIDTH:0] - {1'b0, divisor};
    rem_out = q_bit ? diff : shifted[WIDTH:0];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative radix-2 restoring divider with a valid/ready handshake on input and output.
// Only one operation is in flight at a time. A sideband (ctrls) travels with each result.
// Build option SEQ_DIVIDER_SIGNED_EN: two's-complement operands. The divider takes
// magnitudes at accept and fixes the signs when it loads the results.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH                 = 8,
  parameter int CONTROL_SIGNALS_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 dividend,
  input  logic [WIDTH-1:0]                 divisor,
  input  logic [CONTROL_SIGNALS_WIDTH-1:0] ctrls_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 quotient,
  output logic [WIDTH-1:0]                 remainder,
  output logic [CONTROL_SIGNALS_WIDTH-1:0] ctrls_out,
  output logic                             div_by_zero
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_nx;

  logic [WIDTH-1:0]                 dvd_q;   // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]                 dvs_q;
  logic [WIDTH:0]                   rem_q;
  logic [CW-1:0]                    cnt_q;
  logic [CONTROL_SIGNALS_WIDTH-1:0] ctl_q;

  logic             accept;
  logic [WIDTH:0]   rem_nx;
  logic             q_bit;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] op_dvd, op_dvs;
  logic [WIDTH-1:0] res_quo, res_rem, dbz_rem;

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .dvd_bit (dvd_q[WIDTH-1]),
    .divisor (dvs_q),
    .rem_out (rem_nx),
    .q_bit   (q_bit)
  );

  assign quo_nx = {dvd_q[WIDTH-2:0], q_bit};

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q, neg_r;

  // The core works on magnitudes. The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
  assign op_dvd  = dividend[WIDTH-1] ? -dividend : dividend;
  assign op_dvs  = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign res_quo = neg_q ? -quo_nx : quo_nx;
  assign res_rem = neg_r ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];
  // The dividend magnitude is still unshifted on the zero-divisor path, so re-signing it gives back the raw dividend.
  assign dbz_rem = neg_r ? -dvd_q : dvd_q;

  // The quotient sign is the XOR of the operand signs. The remainder follows the dividend sign.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
    end
  end
`else
  assign op_dvd  = dividend;
  assign op_dvs  = divisor;
  assign res_quo = quo_nx;
  assign res_rem = rem_nx[WIDTH-1:0];
  assign dbz_rem = dvd_q;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state. A zero divisor skips CALC entirely.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (divisor == '0) ? DONE : CALC;
      CALC:    if (cnt_q == LAST) state_nx = DONE;
      DONE:    if (out_valid && out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture operands, iterate, load results and hold them until the consumer takes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      ctl_q       <= '0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      ctrls_out   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          dvd_q <= op_dvd;
          dvs_q <= op_dvs;
          rem_q <= '0;
          cnt_q <= '0;
          ctl_q <= ctrls_in;
        end
        CALC: begin
          rem_q <= rem_nx;
          dvd_q <= quo_nx;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            out_valid   <= 1'b1;
            quotient    <= res_quo;
            remainder   <= res_rem;
            ctrls_out   <= ctl_q;
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          // DONE without out_valid only happens on the zero-divisor path. Its result is loaded one cycle after accept.
          if (!out_valid) begin
            out_valid   <= 1'b1;
            quotient    <= DBZ_QUOTIENT[WIDTH-1:0];
            remainder   <= dbz_rem;
            ctrls_out   <= ctl_q;
            div_by_zero <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed self-checking bench for seq_restoring_divider (WIDTH=8, ctrls 4 bits).
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic [3:0] ctrls_in = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic [3:0] ctrls_out;
  logic       div_by_zero;

  int total = 0;
  int bad = 0;

  seq_restoring_divider #(.WIDTH(8), .CONTROL_SIGNALS_WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .ctrls_in    (ctrls_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .ctrls_out   (ctrls_out),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Present operands and return once they have been accepted (#1 after the accept edge).
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
    int guard = 0;
    @(negedge clk);
    dividend = a; divisor = b; ctrls_in = c; in_valid = 1'b1;
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    total++;
    if (guard >= 100) begin bad++; $display("FAIL issue_timeout got in_ready=%0b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges from accept until out_valid is seen. Returns -1 on timeout.
  task automatic wait_result(output int lat);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < 60);
    if (!out_valid) lat = -1;
  endtask

  // Let the result transfer (out_ready held at 1).
  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got %0b want 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    total++; if ({quotient, remainder, ctrls_out, div_by_zero} !== 21'd0) begin
      bad++; $display("FAIL rst_outputs got q=%0h r=%0h c=%0h z=%0b want all 0", quotient, remainder, ctrls_out, div_by_zero);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_unsigned_basic();
    int lat;
    issue(8'd200, 8'd7, 4'hA);
    wait_result(lat);
    total++; if (lat !== 8) begin bad++; $display("FAIL basic_latency got %0d want 8", lat); end
    total++; if (quotient !== 8'd28) begin bad++; $display("FAIL basic_quotient got %0d want 28", quotient); end
    total++; if (remainder !== 8'd4) begin bad++; $display("FAIL basic_remainder got %0d want 4", remainder); end
    total++; if (ctrls_out !== 4'hA) begin bad++; $display("FAIL basic_ctrls got %0h want a", ctrls_out); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL basic_dbz got %0b want 0", div_by_zero); end
    drain();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got out_valid=%0b want 0", out_valid); end
  endtask

  task automatic test_boundaries();
    logic [7:0] va[3] = '{8'd255, 8'd5, 8'd255};
    logic [7:0] vb[3] = '{8'd1,   8'd9, 8'd255};
    logic [7:0] eq[3] = '{8'd255, 8'd0, 8'd1};
    logic [7:0] er[3] = '{8'd0,   8'd5, 8'd0};
    int lat;
    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i], 4'(i + 1));
      wait_result(lat);
      total++; if (lat !== 8) begin bad++; $display("FAIL bound%0d_latency got %0d want 8", i, lat); end
      total++; if ({quotient, remainder} !== {eq[i], er[i]}) begin
        bad++; $display("FAIL bound%0d_result got %0d r %0d want %0d r %0d", i, quotient, remainder, eq[i], er[i]);
      end
      total++; if (ctrls_out !== 4'(i + 1)) begin bad++; $display("FAIL bound%0d_ctrls got %0h want %0h", i, ctrls_out, i + 1); end
      drain();
    end
  endtask

  task automatic test_div_by_zero();
    int lat;
    issue(8'd13, 8'd0, 4'h5);
    wait_result(lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL dbz_latency got %0d want 1", lat); end
    total++; if (quotient !== 8'hFF) begin bad++; $display("FAIL dbz_quotient got %0h want ff", quotient); end
    total++; if (remainder !== 8'd13) begin bad++; $display("FAIL dbz_remainder got %0d want 13", remainder); end
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag got %0b want 1", div_by_zero); end
    total++; if (ctrls_out !== 4'h5) begin bad++; $display("FAIL dbz_ctrls got %0h want 5", ctrls_out); end
    drain();
    issue(8'd10, 8'd3, 4'h1);
    wait_result(lat);
    total++; if ({quotient, remainder} !== {8'd3, 8'd1}) begin
      bad++; $display("FAIL dbz_next_result got %0d r %0d want 3 r 1", quotient, remainder);
    end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL dbz_next_flag got %0b want 0", div_by_zero); end
    drain();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic ok_stable, ok_ready;
    out_ready = 1'b0;
    issue(8'd50, 8'd6, 4'h5);
    wait_result(lat);
    total++; if ({quotient, remainder, ctrls_out} !== {8'd8, 8'd2, 4'h5}) begin
      bad++; $display("FAIL bp_result got %0d r %0d c %0h want 8 r 2 c 5", quotient, remainder, ctrls_out);
    end
    @(negedge clk);
    dividend = 8'd77; divisor = 8'd10; ctrls_in = 4'h3; in_valid = 1'b1;
    ok_stable = 1'b1; ok_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (!out_valid || quotient !== 8'd8 || remainder !== 8'd2 || ctrls_out !== 4'h5) ok_stable = 1'b0;
      if (in_ready !== 1'b0) ok_ready = 1'b0;
    end
    total++; if (ok_stable !== 1'b1) begin bad++; $display("FAIL bp_hold got v=%0b q=%0d r=%0d want held 8 r 2", out_valid, quotient, remainder); end
    total++; if (ok_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready got nonzero want 0 while held"); end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL bp_transfer got v=%0b rdy=%0b want v=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(lat);
    total++; if (lat !== 8) begin bad++; $display("FAIL bp_next_latency got %0d want 8", lat); end
    total++; if ({quotient, remainder, ctrls_out} !== {8'd7, 8'd7, 4'h3}) begin
      bad++; $display("FAIL bp_next_result got %0d r %0d c %0h want 7 r 7 c 3", quotient, remainder, ctrls_out);
    end
    drain();
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    logic seen;
    issue(8'd100, 8'd3, 4'h6);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready got %0b want 0", in_ready); end
    @(posedge clk); #1;
    total++; if ({out_valid, quotient, remainder, ctrls_out, div_by_zero} !== 22'd0) begin
      bad++; $display("FAIL midrst_outputs got v=%0b q=%0h r=%0h c=%0h z=%0b want all 0", out_valid, quotient, remainder, ctrls_out, div_by_zero);
    end
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_abandoned got out_valid=1 want never"); end
    issue(8'd100, 8'd3, 4'h9);
    wait_result(lat);
    total++; if ({quotient, remainder, ctrls_out} !== {8'd33, 8'd1, 4'h9}) begin
      bad++; $display("FAIL midrst_next got %0d r %0d c %0h want 33 r 1 c 9", quotient, remainder, ctrls_out);
    end
    total++; if (lat !== 8) begin bad++; $display("FAIL midrst_next_latency got %0d want 8", lat); end
    drain();
  endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
  task automatic test_signed();
    logic [7:0] va[3] = '{8'h9C, 8'h80, 8'd100};
    logic [7:0] vb[3] = '{8'd7,  8'hFF, 8'hF9};
    logic [7:0] eq[3] = '{8'hF2, 8'h80, 8'hF2};
    logic [7:0] er[3] = '{8'hFE, 8'h00, 8'h02};
    int lat;
    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i], 4'h2);
      wait_result(lat);
      total++; if ({quotient, remainder, div_by_zero} !== {eq[i], er[i], 1'b0}) begin
        bad++; $display("FAIL signed%0d got %0h r %0h z %0b want %0h r %0h z 0", i, quotient, remainder, div_by_zero, eq[i], er[i]);
      end
      total++; if (lat !== 8) begin bad++; $display("FAIL signed%0d_latency got %0d want 8", i, lat); end
      drain();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_unsigned_basic();
    test_boundaries();
    test_div_by_zero();
    test_back_to_back();
    test_reset_mid_calc();
`ifdef SEQ_DIVIDER_SIGNED_EN
    test_signed();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
